odu_cfg_master: RTL and testbench
=================================

ODU_CFG_MASTER -- requirements
Module: odu_cfg_master

Interface
REQ-001 Param DATA_WIDTH_CFG, 16, cfg data bus width.
REQ-002 Param ADDR_WIDTH_CFG, 4, cfg address width.
REQ-003 Param VERIFY, 1, 1 = read back and compare every written word; 0 = write only.
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 cmd_valid  in  1  request to program one channel configuration.
REQ-007 cmd_ready  out  1  high only in IDLE.
REQ-008 cmd_enable_chid  in  80  per-channel enable bits to program.
REQ-009 cmd_type_chid  in  80  per-channel type bits to program.
REQ-010 cfg_n_cs / cfg_n_we / cfg_n_oe  out  1 each  active-low bus strobes toward the cfg register slave.
REQ-011 cfg_addr  out  ADDR_WIDTH_CFG  bus address; cfg_din  out  DATA_WIDTH_CFG  write data.
REQ-012 cfg_dout  in  DATA_WIDTH_CFG  slave read data, valid the cycle after a read strobe.
REQ-013 busy  out  1  high from cmd accept until done/err pulse inclusive.
REQ-014 done  out  1  one-cycle pulse, programming and start write complete.
REQ-015 err  out  1  one-cycle pulse on read-back mismatch; err_addr  out  ADDR_WIDTH_CFG  failing address, held until next accept.

Function
REQ-016 Address map: 0 = start reg (bit0 = start); 1..5 = enable_chid[15:0]..[79:64]; 6..10 = type_chid[15:0]..[79:64]; words 16 bits each.
REQ-017 Accept on clk edge with cmd_valid && cmd_ready; both 80-bit vectors snapshotted at that edge; later input changes ignored.
REQ-018 FSM states: IDLE, WR, RD, CMP, GAP, START, DONE, ERR; word index counter 0..9 maps to addresses 1..10 in order.
REQ-019 WR: exactly one cycle cs=0, we=0, oe=1, addr/din = current word.
REQ-020 VERIFY=1: WR -> RD (one cycle cs=0, oe=0, we=1, same addr) -> CMP (cs=1; compare cfg_dout to written word).
REQ-021 CMP match: index<9 -> WR of next word; index=9 -> START. Mismatch -> ERR.
REQ-022 VERIFY=0: WR -> GAP (cs=1, one cycle) -> next WR, or START after word 9.
REQ-023 START: one cycle write addr 0, din = 16'h0001; then DONE.
REQ-024 DONE: done=1 one cycle, busy=1, strobes inactive; next state IDLE.
REQ-025 ERR: err=1 one cycle, err_addr = mismatching address; start register NOT written; next state IDLE.
REQ-026 Latency (accept edge = cycle 0): VERIFY=1 WR strobes cycles 1,4,...,28, START cycle 31, done cycle 32; VERIFY=0 WR cycles 1,3,...,19, START cycle 21, done cycle 22.
REQ-027 cfg_n_we and cfg_n_oe never low simultaneously; both high whenever cfg_n_cs high.
REQ-028 All bus outputs registered; no combinational path cfg_dout -> any output.
REQ-029 cmd_valid during busy ignored (cmd_ready=0); new command accepted at earliest the cycle after done/err.
REQ-030 Bus outputs outside strobe cycles: cs/we/oe=1, addr and din hold last value.

Reset
REQ-031 rst=1: state IDLE, index 0, cfg_n_cs/we/oe=1, cfg_addr=0, cfg_din=0, busy=0, done=0, err=0, err_addr=0, cmd_ready=1 the cycle after rst deasserts.
REQ-032 rst mid-transaction: strobes deassert at that edge, no further bus activity, snapshot discarded.

Structure
REQ-033 Package odu_cfg_pkg: address map constants (ADDR_START, ADDR_EN_BASE, ADDR_TYPE_BASE, NUM_WORDS=5), START_VALUE, FSM state encoding; shared with the slave register block.
REQ-034 Single module, no sub-module; word select is an index-driven mux inside odu_cfg_master.

Verification
REQ-035 VERIFY=1, echoing slave model, enable=80'h0123_4567_89AB_CDEF_0F0F, type=80'hFFFF_0000_A5A5_5A5A_1234 -> writes addr1=16'h0F0F..addr5=16'h0123, addr6=16'h1234..addr10=16'hFFFF, addr0=16'h0001 at cycle 31, done at cycle 32.
REQ-036 VERIFY=1, slave corrupts read of addr 7 (returns 16'h0000 for 16'h5A5A) -> err pulse, err_addr=7, no write to addr 0, no done, cmd_ready=1 next cycle.
REQ-037 VERIFY=0, all-ones vectors -> ten writes of 16'hFFFF on odd cycles 1..19, no oe strobes, start write cycle 21, done cycle 22.
REQ-038 rst asserted at cycle 10 of a VERIFY=1 run -> strobes high at that edge, busy=0, no done/err; fresh command then completes normally.
REQ-039 cmd_valid held high continuously with changing data -> second command accepted only after done; each run writes its own snapshot; monitor asserts REQ-027 every cycle.

Source files
------------

// File: rtl/odu_cfg_pkg.sv
// Shared definitions for the ODU channel configuration bus: address map,
// start-register value and master FSM encoding. The slave register block
// imports the same package so both sides agree on the word layout.
package odu_cfg_pkg;

    localparam int CFG_WORD_WIDTH = 16;
    localparam int NUM_WORDS      = 5;
    localparam int CHID_WIDTH     = NUM_WORDS * CFG_WORD_WIDTH;

    localparam logic [3:0] ADDR_START     = 4'd0;
    localparam logic [3:0] ADDR_EN_BASE   = 4'd1;
    localparam logic [3:0] ADDR_TYPE_BASE = 4'd6;
    localparam logic [3:0] LAST_INDEX     = 4'd9;

    localparam logic [CFG_WORD_WIDTH-1:0] START_VALUE = 16'h0001;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WR    = 3'd1,
        ST_RD    = 3'd2,
        ST_CMP   = 3'd3,
        ST_GAP   = 3'd4,
        ST_START = 3'd5,
        ST_DONE  = 3'd6,
        ST_ERR   = 3'd7
    } odu_cfg_state_e;

    // Word index 0..4 lands on the enable block, 5..9 on the type block.
    function automatic logic [3:0] index_to_addr(input logic [3:0] idx);
        logic [3:0] addr;
        if (idx < 4'(NUM_WORDS)) begin
            addr = ADDR_EN_BASE + idx;
        end else begin
            addr = ADDR_TYPE_BASE + (idx - 4'(NUM_WORDS));
        end
        return addr;
    endfunction

endpackage

// File: rtl/odu_cfg_master.sv
// Programs one ODU channel configuration (80 enable bits + 80 type bits) into
// the cfg register slave as ten 16-bit words, optionally reading each word
// back for comparison, then writes the start register. All bus outputs are
// registered; the FSM sets next-cycle outputs together with the next state.
module odu_cfg_master
    import odu_cfg_pkg::*;
#(
    parameter int DATA_WIDTH_CFG = 16,
    parameter int ADDR_WIDTH_CFG = 4,
    parameter bit VERIFY         = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [CHID_WIDTH-1:0]     cmd_enable_chid,
    input  logic [CHID_WIDTH-1:0]     cmd_type_chid,
    output logic                      cfg_n_cs,
    output logic                      cfg_n_we,
    output logic                      cfg_n_oe,
    output logic [ADDR_WIDTH_CFG-1:0] cfg_addr,
    output logic [DATA_WIDTH_CFG-1:0] cfg_din,
    input  logic [DATA_WIDTH_CFG-1:0] cfg_dout,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [ADDR_WIDTH_CFG-1:0] err_addr
);

    odu_cfg_state_e            state_r;
    logic [3:0]                index_r;
    logic                      first_r;
    logic [CHID_WIDTH-1:0]     en_snap_r;
    logic [CHID_WIDTH-1:0]     ty_snap_r;

    logic [3:0]                nxt_index_s;
    logic [CFG_WORD_WIDTH-1:0] cur_word_s;
    logic [CFG_WORD_WIDTH-1:0] nxt_word_s;

    // Index-driven word select over the snapshotted enable/type vectors.
    function automatic logic [CFG_WORD_WIDTH-1:0] word_at(
        input logic [3:0]            idx,
        input logic [CHID_WIDTH-1:0] en,
        input logic [CHID_WIDTH-1:0] ty
    );
        logic [CFG_WORD_WIDTH-1:0] w;
        case (idx)
            4'd0:    w = en[0*CFG_WORD_WIDTH +: CFG_WORD_WIDTH];
            4'd1:    w = en[1*CFG_WORD_WIDTH +: CFG_WORD_WIDTH];
            4'd2:    w = en[2*CFG_WORD_WIDTH +: CFG_WORD_WIDTH];
            4'd3:    w = en[3*CFG_WORD_WIDTH +: CFG_WORD_WIDTH];
            4'd4:    w = en[4*CFG_WORD_WIDTH +: CFG_WORD_WIDTH];
            4'd5:    w = ty[0*CFG_WORD_WIDTH +: CFG_WORD_WIDTH];
            4'd6:    w = ty[1*CFG_WORD_WIDTH +: CFG_WORD_WIDTH];
            4'd7:    w = ty[2*CFG_WORD_WIDTH +: CFG_WORD_WIDTH];
            4'd8:    w = ty[3*CFG_WORD_WIDTH +: CFG_WORD_WIDTH];
            4'd9:    w = ty[4*CFG_WORD_WIDTH +: CFG_WORD_WIDTH];
            default: w = {CFG_WORD_WIDTH{1'b0}};
        endcase
        return w;
    endfunction

    // Current and next word so the FSM can launch the following write directly.
    always_comb begin
        nxt_index_s = index_r + 4'd1;
        cur_word_s  = word_at(index_r, en_snap_r, ty_snap_r);
        nxt_word_s  = word_at(nxt_index_s, en_snap_r, ty_snap_r);
    end

    // Programming sequencer: state, word index, snapshot and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            index_r   <= 4'd0;
            first_r   <= 1'b0;
            en_snap_r <= {CHID_WIDTH{1'b0}};
            ty_snap_r <= {CHID_WIDTH{1'b0}};
            cfg_n_cs  <= 1'b1;
            cfg_n_we  <= 1'b1;
            cfg_n_oe  <= 1'b1;
            cfg_addr  <= {ADDR_WIDTH_CFG{1'b0}};
            cfg_din   <= {DATA_WIDTH_CFG{1'b0}};
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_addr  <= {ADDR_WIDTH_CFG{1'b0}};
            cmd_ready <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        // Accept: freeze both vectors; a one-cycle idle bus
                        // slot precedes the first write.
                        en_snap_r <= cmd_enable_chid;
                        ty_snap_r <= cmd_type_chid;
                        index_r   <= 4'd0;
                        first_r   <= 1'b1;
                        busy      <= 1'b1;
                        cmd_ready <= 1'b0;
                        err_addr  <= {ADDR_WIDTH_CFG{1'b0}};
                        state_r   <= ST_GAP;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (first_r) begin
                        first_r  <= 1'b0;
                        cfg_n_cs <= 1'b0;
                        cfg_n_we <= 1'b0;
                        cfg_addr <= ADDR_WIDTH_CFG'(index_to_addr(index_r));
                        cfg_din  <= DATA_WIDTH_CFG'(cur_word_s);
                        state_r  <= ST_WR;
                    end else if (index_r == LAST_INDEX) begin
                        cfg_n_cs <= 1'b0;
                        cfg_n_we <= 1'b0;
                        cfg_addr <= ADDR_WIDTH_CFG'(ADDR_START);
                        cfg_din  <= DATA_WIDTH_CFG'(START_VALUE);
                        state_r  <= ST_START;
                    end else begin
                        index_r  <= nxt_index_s;
                        cfg_n_cs <= 1'b0;
                        cfg_n_we <= 1'b0;
                        cfg_addr <= ADDR_WIDTH_CFG'(index_to_addr(nxt_index_s));
                        cfg_din  <= DATA_WIDTH_CFG'(nxt_word_s);
                        state_r  <= ST_WR;
                    end
                end
                ST_WR: begin
                    cfg_n_we <= 1'b1;
                    if (VERIFY) begin
                        // Same address, switch the strobe from write to read.
                        cfg_n_cs <= 1'b0;
                        cfg_n_oe <= 1'b0;
                        state_r  <= ST_RD;
                    end else begin
                        cfg_n_cs <= 1'b1;
                        state_r  <= ST_GAP;
                    end
                end
                ST_RD: begin
                    cfg_n_cs <= 1'b1;
                    cfg_n_oe <= 1'b1;
                    state_r  <= ST_CMP;
                end
                ST_CMP: begin
                    // Slave read data is valid in this cycle.
                    if (cfg_dout != DATA_WIDTH_CFG'(cur_word_s)) begin
                        err      <= 1'b1;
                        err_addr <= ADDR_WIDTH_CFG'(index_to_addr(index_r));
                        state_r  <= ST_ERR;
                    end else if (index_r == LAST_INDEX) begin
                        cfg_n_cs <= 1'b0;
                        cfg_n_we <= 1'b0;
                        cfg_addr <= ADDR_WIDTH_CFG'(ADDR_START);
                        cfg_din  <= DATA_WIDTH_CFG'(START_VALUE);
                        state_r  <= ST_START;
                    end else begin
                        index_r  <= nxt_index_s;
                        cfg_n_cs <= 1'b0;
                        cfg_n_we <= 1'b0;
                        cfg_addr <= ADDR_WIDTH_CFG'(index_to_addr(nxt_index_s));
                        cfg_din  <= DATA_WIDTH_CFG'(nxt_word_s);
                        state_r  <= ST_WR;
                    end
                end
                ST_START: begin
                    cfg_n_cs <= 1'b1;
                    cfg_n_we <= 1'b1;
                    done     <= 1'b1;
                    state_r  <= ST_DONE;
                end
                ST_DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state_r   <= ST_IDLE;
                end
                ST_ERR: begin
                    err       <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    cfg_n_cs  <= 1'b1;
                    cfg_n_we  <= 1'b1;
                    cfg_n_oe  <= 1'b1;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    err       <= 1'b0;
                    cmd_ready <= 1'b1;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_odu_cfg_master.sv
// Bench for odu_cfg_master: one VERIFY=1 and one VERIFY=0 instance, each with
// an echoing slave model. Expected bus writes are queued when a command is
// issued and popped by a bus monitor as the writes appear.
module tb_odu_cfg_master;
    import odu_cfg_pkg::*;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam logic [79:0] EN_A = 80'h0123_4567_89AB_CDEF_0F0F;
    localparam logic [79:0] TY_A = 80'hFFFF_0000_A5A5_5A5A_1234;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          cmd_valid [2];
    logic          cmd_ready [2];
    logic [79:0]   cmd_enable_chid;
    logic [79:0]   cmd_type_chid;
    logic          cfg_n_cs  [2];
    logic          cfg_n_we  [2];
    logic          cfg_n_oe  [2];
    logic [AW-1:0] cfg_addr  [2];
    logic [DW-1:0] cfg_din   [2];
    logic [DW-1:0] cfg_dout  [2];
    logic          busy      [2];
    logic          done      [2];
    logic          err       [2];
    logic [AW-1:0] err_addr  [2];

    // Instance 0 verifies by read-back, instance 1 is write-only.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        odu_cfg_master #(
            .DATA_WIDTH_CFG(DW),
            .ADDR_WIDTH_CFG(AW),
            .VERIFY        (g == 0 ? 1'b1 : 1'b0)
        ) u_dut (
            .clk            (clk),
            .rst            (rst),
            .cmd_valid      (cmd_valid[g]),
            .cmd_ready      (cmd_ready[g]),
            .cmd_enable_chid(cmd_enable_chid),
            .cmd_type_chid  (cmd_type_chid),
            .cfg_n_cs       (cfg_n_cs[g]),
            .cfg_n_we       (cfg_n_we[g]),
            .cfg_n_oe       (cfg_n_oe[g]),
            .cfg_addr       (cfg_addr[g]),
            .cfg_din        (cfg_din[g]),
            .cfg_dout       (cfg_dout[g]),
            .busy           (busy[g]),
            .done           (done[g]),
            .err            (err[g]),
            .err_addr       (err_addr[g])
        );
    end

    typedef struct {
        int          g;
        int          cyc;
        logic [3:0]  addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        int          g;
        logic [79:0] en;
        logic [79:0] ty;
        int          corrupt;
        bit          exp_err;
        int          err_at;
    } vec_t;

    wr_t         exp_q[$];
    vec_t        vecs[8];
    logic [15:0] mem [2][16];
    int          corrupt [2];
    bit          waiting [2];
    int          cyc = 0;
    int          acc_cyc [2] = '{0, 0};
    int          n_vec = 0;
    int          n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_word(input logic [79:0] en, input logic [79:0] ty, input int i);
        logic [79:0] v;
        v = (i < 5) ? (en >> (16 * i)) : (ty >> (16 * (i - 5)));
        return v[15:0];
    endfunction

    task automatic push_expected(input int g, input logic [79:0] en, input logic [79:0] ty,
                                 input int last_idx, input bit with_start);
        for (int i = 0; i <= last_idx; i++) begin
            exp_q.push_back('{g, (g == 0) ? 1 + 3 * i : 1 + 2 * i, 4'(i + 1), exp_word(en, ty, i)});
        end
        if (with_start) begin
            exp_q.push_back('{g, (g == 0) ? 31 : 21, 4'd0, 16'h0001});
        end
    endtask

    // Slave register model: stores writes, returns read data one cycle later.
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (!cfg_n_cs[g] && !cfg_n_we[g]) mem[g][cfg_addr[g]] <= cfg_din[g];
            if (!cfg_n_cs[g] && !cfg_n_oe[g]) begin
                cfg_dout[g] <= (corrupt[g] != 0 && int'(cfg_addr[g]) == corrupt[g]) ? 16'h0000
                                                                                   : mem[g][cfg_addr[g]];
            end
        end
    end

    // Cycle counter and accept-edge timestamps (accept edge = cycle 0).
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int g = 0; g < 2; g++) begin
            if (!rst && cmd_valid[g] && cmd_ready[g]) acc_cyc[g] <= cyc + 1;
        end
    end

    // Bus monitor: strobe rules every cycle, scoreboard pop on each write.
    always @(negedge clk) begin
        if (!rst) begin
            for (int g = 0; g < 2; g++) begin
                int  rel;
                wr_t e;
                rel = cyc - acc_cyc[g];
                check("strobe_rule", {31'd0, (!cfg_n_we[g] && !cfg_n_oe[g]) ||
                                             (cfg_n_cs[g] && (!cfg_n_we[g] || !cfg_n_oe[g]))}, 32'd0);
                if (!cfg_n_cs[g] && !cfg_n_we[g]) begin
                    if (exp_q.size() == 0 || exp_q[0].g != g) begin
                        n_vec++;
                        n_miss++;
                        $display("FAIL unexpected_write: inst %0d addr %0h data %0h rel cycle %0d, expected none",
                                 g, cfg_addr[g], cfg_din[g], rel);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_addr", 32'(cfg_addr[g]), 32'(e.addr));
                        check("wr_data", 32'(cfg_din[g]), 32'(e.data));
                        check("wr_cycle", rel, e.cyc);
                    end
                end
                if ((done[g] || err[g]) && !waiting[g]) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_pulse: inst %0d done=%0b err=%0b, expected none", g, done[g], err[g]);
                end
            end
            check("v0_no_read", {31'd0, cfg_n_oe[1]}, 32'd1);
        end
    end

    task automatic wait_ready(input int g);
        for (int k = 0; k < 100; k++) begin
            if (cmd_ready[g]) break;
            @(negedge clk);
        end
        check("ready_wait", {31'd0, cmd_ready[g]}, 32'd1);
    endtask

    task automatic wait_pulse(input int g, output bit got);
        got = 1'b0;
        for (int k = 0; k < 80; k++) begin
            if (done[g] || err[g]) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            n_vec++;
            n_miss++;
            $display("FAIL pulse_timeout: inst %0d got no done/err within 80 cycles, expected one", g);
        end
    endtask

    task automatic run_vec(input vec_t v);
        bit got;
        int last;
        wait_ready(v.g);
        cmd_enable_chid = v.en;
        cmd_type_chid   = v.ty;
        corrupt[v.g]    = v.corrupt;
        if (v.exp_err) push_expected(v.g, v.en, v.ty, v.err_at - 1, 1'b0);
        else           push_expected(v.g, v.en, v.ty, 9, 1'b1);
        waiting[v.g]    = 1'b1;
        cmd_valid[v.g]  = 1'b1;
        @(negedge clk);
        cmd_valid[v.g]  = 1'b0;
        cmd_enable_chid = ~v.en;
        cmd_type_chid   = ~v.ty;
        check("accept_cycle", cyc - acc_cyc[v.g], 32'd0);
        check("busy_on_accept", {31'd0, busy[v.g]}, 32'd1);
        check("ready_low_busy", {31'd0, cmd_ready[v.g]}, 32'd0);
        wait_pulse(v.g, got);
        if (got) begin
            last = v.exp_err ? 4 + 3 * (v.err_at - 1) : ((v.g == 0) ? 32 : 22);
            check("pulse_err", {31'd0, err[v.g]}, {31'd0, v.exp_err});
            check("pulse_done", {31'd0, done[v.g]}, {31'd0, ~v.exp_err});
            check("pulse_cycle", cyc - acc_cyc[v.g], last);
            check("busy_at_pulse", {31'd0, busy[v.g]}, 32'd1);
            check("sb_drained", exp_q.size(), 32'd0);
            if (v.exp_err) check("err_addr", 32'(err_addr[v.g]), v.err_at);
            @(negedge clk);
            check("ready_after", {31'd0, cmd_ready[v.g]}, 32'd1);
            check("busy_after", {31'd0, busy[v.g]}, 32'd0);
            check("pulse_one_cycle", {30'd0, done[v.g], err[v.g]}, 32'd0);
            if (v.exp_err) begin
                check("err_addr_held", 32'(err_addr[v.g]), v.err_at);
                check("addr_hold", 32'(cfg_addr[v.g]), v.err_at);
                check("din_hold", 32'(cfg_din[v.g]), 32'(exp_word(v.en, v.ty, v.err_at - 1)));
            end else begin
                check("addr_hold", 32'(cfg_addr[v.g]), 32'd0);
                check("din_hold", 32'(cfg_din[v.g]), 32'd1);
            end
        end
        waiting[v.g] = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        bit got;
        int first_acc;
        vecs[0] = '{0, EN_A, TY_A, 0, 1'b0, 0};
        vecs[1] = '{0, EN_A, TY_A, 7, 1'b1, 7};
        vecs[2] = '{1, {80{1'b1}}, {80{1'b1}}, 0, 1'b0, 0};
        vecs[3] = '{1, EN_A, TY_A, 3, 1'b0, 0};
        vecs[4] = '{0, 80'h0, {16'hBEEF, 64'h0}, 10, 1'b1, 10};
        vecs[5] = '{0, 80'h0000_1111_2222_3333_8001, TY_A, 1, 1'b1, 1};
        vecs[6] = '{1, {5{16'hAAAA}}, {5{16'h5555}}, 0, 1'b0, 0};
        vecs[7] = '{0, {5{16'h5555}}, {5{16'hC3C3}}, 0, 1'b0, 0};

        rst             = 1'b1;
        cmd_valid[0]    = 1'b0;
        cmd_valid[1]    = 1'b0;
        corrupt[0]      = 0;
        corrupt[1]      = 0;
        waiting[0]      = 1'b0;
        waiting[1]      = 1'b0;
        cmd_enable_chid = 80'h0;
        cmd_type_chid   = 80'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check("rst_cs", {31'd0, cfg_n_cs[g]}, 32'd1);
            check("rst_we", {31'd0, cfg_n_we[g]}, 32'd1);
            check("rst_oe", {31'd0, cfg_n_oe[g]}, 32'd1);
            check("rst_addr", 32'(cfg_addr[g]), 32'd0);
            check("rst_din", 32'(cfg_din[g]), 32'd0);
            check("rst_busy", {31'd0, busy[g]}, 32'd0);
            check("rst_done_err", {30'd0, done[g], err[g]}, 32'd0);
            check("rst_err_addr", 32'(err_addr[g]), 32'd0);
            check("rst_ready", {31'd0, cmd_ready[g]}, 32'd1);
        end

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Reset in the middle of a verifying run, then a clean rerun.
        wait_ready(0);
        cmd_enable_chid = EN_A;
        cmd_type_chid   = TY_A;
        corrupt[0]      = 0;
        push_expected(0, EN_A, TY_A, 2, 1'b0);
        waiting[0]      = 1'b1;
        cmd_valid[0]    = 1'b1;
        @(negedge clk);
        cmd_valid[0] = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_rst_drained", exp_q.size(), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_cycle", cyc - acc_cyc[0], 32'd10);
        check("midrst_strobes", {29'd0, cfg_n_cs[0], cfg_n_we[0], cfg_n_oe[0]}, 32'd7);
        check("midrst_busy", {31'd0, busy[0]}, 32'd0);
        check("midrst_pulses", {30'd0, done[0], err[0]}, 32'd0);
        rst        = 1'b0;
        waiting[0] = 1'b0;
        @(negedge clk);
        check("midrst_ready", {31'd0, cmd_ready[0]}, 32'd1);
        check("midrst_addr", 32'(cfg_addr[0]), 32'd0);
        repeat (40) @(negedge clk);
        run_vec(vecs[0]);

        // cmd_valid held high with changing data: second accept waits for done.
        wait_ready(0);
        cmd_enable_chid = EN_A;
        cmd_type_chid   = TY_A;
        push_expected(0, EN_A, TY_A, 9, 1'b1);
        waiting[0]   = 1'b1;
        cmd_valid[0] = 1'b1;
        @(negedge clk);
        first_acc       = acc_cyc[0];
        cmd_enable_chid = {5{16'h1357}};
        cmd_type_chid   = {5{16'h2468}};
        wait_pulse(0, got);
        check("hold_done1_cycle", cyc - first_acc, 32'd32);
        check("hold_done1_drained", exp_q.size(), 32'd0);
        push_expected(0, {5{16'h1357}}, {5{16'h2468}}, 9, 1'b1);
        for (int k = 0; k < 10; k++) begin
            if (acc_cyc[0] != first_acc) break;
            @(negedge clk);
        end
        check("hold_second_accept", acc_cyc[0] - first_acc, 32'd34);
        cmd_valid[0]    = 1'b0;
        cmd_enable_chid = 80'h0;
        cmd_type_chid   = 80'h0;
        wait_pulse(0, got);
        check("hold_done2_cycle", cyc - acc_cyc[0], 32'd32);
        check("hold_done2_drained", exp_q.size(), 32'd0);
        @(negedge clk);
        waiting[0] = 1'b0;
        exp_q.delete();

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
